sub_serial: RTL
===============

# sub_serial

Bit-serial 8-bit subtractor, the inverse companion of the serial adder in the same arithmetic datapath family. It captures a minuend and subtrahend on a start request and produces `a - b` LSB-first, one bit per clock, into a shift register. After eight cycles it reports the result with a borrow-out flag, and optionally a signed-overflow flag. The block holds the result until the controller acknowledges it.

## Interface
Parameters:
- `IDLE`, default 2'd0: state encoding, waiting for start.
- `SUB`, default 2'd1: state encoding, subtracting one bit per cycle.
- `DONE`, default 2'd2: state encoding, result held.

Ports:
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: start request in IDLE; acknowledge in DONE; ignored in SUB.
- `a`, input, 8: minuend, sampled only on the start edge.
- `b`, input, 8: subtrahend, sampled only on the start edge.
- `out`, output reg, 8: difference shift register.
- `borrow`, output reg, 1: running borrow; final value is the borrow-out.
- `done`, output, 1: high exactly while state == DONE.
- `ovf`, output reg, 1: signed overflow (see Configuration).

## Operation
- Internal registers: `a_reg[7:0]`, `b_reg[7:0]`, `count[2:0]`, `state[1:0]`.
- Reset, asynchronous, any time including mid-operation:
  - state=IDLE; out, borrow, ovf, a_reg, b_reg and count all 0.
  - done=0 immediately.
- IDLE:
  - en=1: load a_reg←a, b_reg←b; clear out, borrow, count and ovf; go to SUB.
  - en=0: hold all registers.
- SUB, once per cycle:
  - d = a_reg[0]^b_reg[0]^borrow.
  - out←{d,out[7:1]}.
  - borrow←(~a_reg[0]&b_reg[0]) | (~(a_reg[0]^b_reg[0])&borrow).
  - a_reg←a_reg>>1; b_reg←b_reg>>1; count←count+1.
  - count==7: go to DONE; otherwise stay in SUB.
  - en, a and b are ignored.
- DONE:
  - Hold out, borrow and ovf.
  - en=1: go to IDLE, registers unchanged.
  - en=0: stay in DONE.
  - A new operation therefore needs en in DONE, then en in IDLE.
- Unused state encoding 2'd3: go to IDLE on the next edge with no register updates.
- Arithmetic:
  - out = (a − b) mod 256.
  - borrow=1 iff a < b, unsigned.
  - count wraps 7→0 only on the DONE transition, which is harmless.

## Timing
- Start edge T (IDLE, en=1): operands captured; state=SUB after T.
- Edges T+1 … T+8: eight SUB cycles; result bit i enters out[7] at edge T+1+i.
- After edge T+8: state=DONE, done=1, and out, borrow and ovf are final.
- Latency: 8 cycles from the start edge to done.
- done is combinational from state and needs no extra register stage.
- Outputs stay stable for the whole DONE residency.
- Minimum start-to-start spacing: 10 cycles (start + 8 SUB + acknowledge).

## Configuration
- Macro: `SUB_SERIAL_OVF_EN`.
- Defined: on the SUB cycle with count==7, a_reg[0] and b_reg[0] hold the original a[7] and b[7].
  - ovf←(a_reg[0]^b_reg[0]) & (d^a_reg[0]).
  - ovf is cleared on reset and on start, and held in DONE.
- Undefined: the ovf register and its logic are omitted; the ovf port is driven constant 0.
- The port list is identical in both builds.

## Test plan
- Reset, then en=1 with a=8'h5A, b=8'h3C → after 8 SUB cycles done=1, out=8'h1E, borrow=0, ovf=0.
- a=8'h10, b=8'h20 → out=8'hF0, borrow=1. Check ovf=0 with the macro defined and ovf=0 without it.
- a=8'h80, b=8'h01 → out=8'h7F, borrow=0; ovf=1 with the macro defined, 0 without.
- a=8'h33, b=8'h33 with en held high through SUB and a/b changed mid-run → out=8'h00 and borrow=0 at done. Expect exactly 8 SUB cycles, then DONE, then IDLE on the next en (no restart from SUB).
- Assert rst asynchronously at SUB cycle 4 of a=8'hFF, b=8'h01 → out, borrow and done are 0 immediately and state=IDLE. A fresh start with a=8'h09, b=8'h04 yields out=8'h05.
- In DONE, hold en=0 for 20 cycles → done and out stay stable. Then pulse en twice (DONE→IDLE→start) with a=8'h00, b=8'hFF → out=8'h01, borrow=1.

Source files
------------

// File: rtl/sub_serial.sv
// +--------------------------------------------------------------------------+
// | Module      : sub_serial                                                 |
// | Description : Bit-serial 8-bit subtractor. Captures a and b on a start   |
// |               request, produces a - b LSB-first over eight cycles, and   |
// |               holds the result with its borrow-out until acknowledged.   |
// |               Optional signed-overflow flag under macro                  |
// |               SUB_SERIAL_OVF_EN; without it the ovf port is tied to 0.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module sub_serial #(
   parameter logic [1:0] IDLE = 2'd0,
   parameter logic [1:0] SUB  = 2'd1,
   parameter logic [1:0] DONE = 2'd2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] out,
   output logic       borrow,
   output logic       done,
   output logic       ovf
);

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_SUB  = SUB,
      ST_DONE = DONE
   } state_t;

   state_t     state;
   logic [7:0] a_reg;
   logic [7:0] b_reg;
   logic [2:0] count;
   logic       d;

   // Difference bit for the current position, using the running borrow
   assign d = a_reg[0] ^ b_reg[0] ^ borrow;

   // done is decoded straight from state so it drops the instant reset hits
   assign done = (state == ST_DONE);

   // Control FSM and serial datapath; reset clears everything asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         out    <= 8'd0;
         borrow <= 1'b0;
         a_reg  <= 8'd0;
         b_reg  <= 8'd0;
         count  <= 3'd0;
`ifdef SUB_SERIAL_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (en) begin
                  a_reg  <= a;
                  b_reg  <= b;
                  out    <= 8'd0;
                  borrow <= 1'b0;
                  count  <= 3'd0;
`ifdef SUB_SERIAL_OVF_EN
                  ovf    <= 1'b0;
`endif
                  state  <= ST_SUB;
               end
            end
            ST_SUB: begin
               out    <= {d, out[7:1]};
               borrow <= (~a_reg[0] & b_reg[0]) |
                         (~(a_reg[0] ^ b_reg[0]) & borrow);
               a_reg  <= a_reg >> 1;
               b_reg  <= b_reg >> 1;
               count  <= count + 3'd1;
               if (count == 3'd7) begin
`ifdef SUB_SERIAL_OVF_EN
                  // Last bit: a_reg[0]/b_reg[0] are the operand sign bits
                  ovf   <= (a_reg[0] ^ b_reg[0]) & (d ^ a_reg[0]);
`endif
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (en) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifndef SUB_SERIAL_OVF_EN
   assign ovf = 1'b0;
`endif

endmodule

`default_nettype wire
